// File: rtl/i2c_edge_detect_mc_pkg.sv
// ---------------------------------------------------------------------------
// i2c_edge_detect_mc_pkg
//   Shared timing helpers and types for the multi-channel I2C edge detector.
//   - filt_act_e    : per-cycle action chosen by a channel filter
//   - clip0         : clamp a signed value at zero
//   - stable_cycles : derive a STABLE_* count from an edge time and clock period
//   - cnt_width     : bits needed to hold a given stability count
//   - max2          : larger of two counts
// ---------------------------------------------------------------------------
package i2c_edge_detect_mc_pkg;

  localparam int unsigned DEF_STABLE_RISE = 4;
  localparam int unsigned DEF_STABLE_FALL = 4;
  localparam int unsigned DEF_CNT_W       = 8;

  typedef enum logic [1:0] {
    FILT_HOLD,     // input agrees with level, counter already at reload
    FILT_COUNT,    // input differs, still counting down
    FILT_COMMIT,   // input differed long enough, take the new level
    FILT_ABANDON   // input returned before commit, report a glitch
  } filt_act_e;

  function automatic int unsigned clip0(input int v);
    return (v < 0) ? 0 : int'(v);
  endfunction

  // Extra samples (beyond the first) needed to cover an edge of t_edge_ns
  // at a clock period of clk_ns; rounds up, never negative.
  function automatic int unsigned stable_cycles(input int unsigned t_edge_ns,
                                                input int unsigned clk_ns);
    int cycles;
    cycles = int'((t_edge_ns + clk_ns - 1) / clk_ns) - 1;
    return clip0(cycles);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while (w < 32 && (64'(1) << w) <= 64'(max_val)) w++;
    return w;
  endfunction

  function automatic int unsigned max2(input int unsigned a,
                                       input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/i2c_edge_detect_mc_filt_ch.sv
// ---------------------------------------------------------------------------
// i2c_edge_filt_ch
//   Single-channel glitch filter: stability counter, committed level,
//   one-cycle edge strobes and a glitch strobe for abandoned transitions.
//   Ports:
//     clk    - system clock
//     rst    - synchronous active-high reset (captures s as the level)
//     s      - sampled line, synchronous to clk
//     lvl    - committed level
//     lohi   - one-cycle pulse after a committed 0->1
//     hilo   - one-cycle pulse after a committed 1->0
//     glitch - one-cycle pulse when a pending change is abandoned
// ---------------------------------------------------------------------------
module i2c_edge_filt_ch
  import i2c_edge_detect_mc_pkg::*;
#(
  parameter int unsigned STABLE_RISE = DEF_STABLE_RISE,
  parameter int unsigned STABLE_FALL = DEF_STABLE_FALL,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  output logic lvl,
  output logic lohi,
  output logic hilo,
  output logic glitch
);

  if (CNT_W < cnt_width(max2(STABLE_RISE, STABLE_FALL))) begin : g_cnt_w_check
    $error("i2c_edge_filt_ch: CNT_W too narrow for STABLE_RISE/STABLE_FALL");
  end

  localparam logic [CNT_W-1:0] RELOAD_RISE = CNT_W'(STABLE_RISE);
  localparam logic [CNT_W-1:0] RELOAD_FALL = CNT_W'(STABLE_FALL);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             lohi_q, lohi_d;
  logic             hilo_q, hilo_d;
  logic             glitch_q, glitch_d;
  logic [CNT_W-1:0] reload;
  filt_act_e        act;

  always_comb begin
    // Reload depends on the level being defended: a high line waits out a fall.
    reload = lvl_q ? RELOAD_FALL : RELOAD_RISE;

    if (s == lvl_q) begin
      act = (cnt_q < reload) ? FILT_ABANDON : FILT_HOLD;
    end else begin
      act = (cnt_q != '0) ? FILT_COUNT : FILT_COMMIT;
    end

    cnt_d    = cnt_q;
    lvl_d    = lvl_q;
    lohi_d   = 1'b0;
    hilo_d   = 1'b0;
    glitch_d = 1'b0;

    unique case (act)
      FILT_HOLD: ;
      FILT_COUNT: begin
        cnt_d = cnt_q - 1'b1;
      end
      FILT_COMMIT: begin
        lvl_d  = s;
        lohi_d = s;
        hilo_d = ~s;
        cnt_d  = s ? RELOAD_FALL : RELOAD_RISE;
      end
      FILT_ABANDON: begin
        glitch_d = 1'b1;
        cnt_d    = reload;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q    <= s;
      cnt_q    <= s ? RELOAD_FALL : RELOAD_RISE;
      lohi_q   <= 1'b0;
      hilo_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      lvl_q    <= lvl_d;
      cnt_q    <= cnt_d;
      lohi_q   <= lohi_d;
      hilo_q   <= hilo_d;
      glitch_q <= glitch_d;
    end
  end

  assign lvl    = lvl_q;
  assign lohi   = lohi_q;
  assign hilo   = hilo_q;
  assign glitch = glitch_q;

endmodule

// File: rtl/i2c_edge_detect_mc.sv
// ---------------------------------------------------------------------------
// i2c_edge_detect_mc
//   Multi-channel glitch-filtered level and edge detector for I2C pad lines.
//   Optional feature macro: I2C_EDGE_DET_SYNC_EN
//     defined   - each lin bit passes a 2-flop synchronizer (idle-high at
//                 power-up, not reset) before filtering; +2 cycles latency
//     undefined - lin feeds the filters directly (caller keeps it synchronous)
//   Ports:
//     clk    - system clock
//     rst    - synchronous active-high reset
//     lin    - raw line inputs, one bit per channel
//     lvl    - filtered committed level per channel
//     lohi   - one-cycle pulse after a committed 0->1
//     hilo   - one-cycle pulse after a committed 1->0
//     glitch - one-cycle pulse when a pending transition is abandoned
// ---------------------------------------------------------------------------
module i2c_edge_detect_mc
  import i2c_edge_detect_mc_pkg::*;
#(
  parameter int unsigned NCH         = 2,
  parameter int unsigned STABLE_RISE = DEF_STABLE_RISE,
  parameter int unsigned STABLE_FALL = DEF_STABLE_FALL,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] lin,
  output logic [NCH-1:0] lvl,
  output logic [NCH-1:0] lohi,
  output logic [NCH-1:0] hilo,
  output logic [NCH-1:0] glitch
);

  if (NCH < 1) begin : g_nch_check
    $error("i2c_edge_detect_mc: NCH must be at least 1");
  end

  logic [NCH-1:0] s;

`ifdef I2C_EDGE_DET_SYNC_EN
  // Synchronizer stages hold the inverted line so that the all-zero power-up
  // state of an unreset flop reads as the idle-high bus level.
  logic [NCH-1:0] sync_meta_n_q, sync_meta_n_d;
  logic [NCH-1:0] sync_out_n_q, sync_out_n_d;

  always_comb begin
    sync_meta_n_d = ~lin;
    sync_out_n_d  = sync_meta_n_q;
  end

  always_ff @(posedge clk) begin
    sync_meta_n_q <= sync_meta_n_d;
    sync_out_n_q  <= sync_out_n_d;
  end

  assign s = ~sync_out_n_q;
`else
  assign s = lin;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    i2c_edge_filt_ch #(
      .STABLE_RISE (STABLE_RISE),
      .STABLE_FALL (STABLE_FALL),
      .CNT_W       (CNT_W)
    ) u_filt (
      .clk    (clk),
      .rst    (rst),
      .s      (s[i]),
      .lvl    (lvl[i]),
      .lohi   (lohi[i]),
      .hilo   (hilo[i]),
      .glitch (glitch[i])
    );
  end

endmodule
